demux_quad1_4: RTL and testbench



---
 rtl/demux_quad1_4.sv | 99 +++++++++
 tb/tb_demux_quad1_4.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/demux_quad1_4.sv
// Quad 1-to-4 demultiplexer: routes tagged 4-bit words into four independent
// per-channel FIFOs with valid/ready handshakes. Optional `DEMUX_STATS_EN adds AcceptCnt.
module demux_quad1_4 #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  InData,
  input  logic [1:0]  InSel,
  input  logic        InValid,
  output logic        InReady,
  output logic [3:0]  OutA,
  output logic [3:0]  OutB,
  output logic [3:0]  OutC,
  output logic [3:0]  OutD,
  output logic [3:0]  OutValid,
  input  logic [3:0]  OutReady
`ifdef DEMUX_STATS_EN
  ,
  output logic [31:0] AcceptCnt
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [3:0]    r_mem   [4][DEPTH];
  logic [PW-1:0] r_wptr  [4];
  logic [PW-1:0] r_rptr  [4];
  logic [CW-1:0] r_count [4];

  logic [3:0] w_full;
  logic [3:0] w_empty;
  logic [3:0] w_push;
  logic [3:0] w_pop;

  for (genvar k = 0; k < 4; k++) begin : g_ch
    assign w_full[k]  = (r_count[k] == CW'(DEPTH));
    assign w_empty[k] = (r_count[k] == '0);
    // A full channel refuses the word even if it pops this cycle: no path from OutReady.
    assign w_push[k]  = InValid & InReady & (InSel == 2'(k));
    assign w_pop[k]   = ~w_empty[k] & OutReady[k];
  end

  assign InReady  = ~w_full[InSel];
  assign OutValid = ~w_empty;

  assign OutA = r_mem[0][r_rptr[0]];
  assign OutB = r_mem[1][r_rptr[1]];
  assign OutC = r_mem[2][r_rptr[2]];
  assign OutD = r_mem[3][r_rptr[3]];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        r_wptr[k]  <= '0;
        r_rptr[k]  <= '0;
        r_count[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (w_push[k]) r_wptr[k] <= r_wptr[k] + PW'(1);
        if (w_pop[k])  r_rptr[k] <= r_rptr[k] + PW'(1);
        unique case ({w_push[k], w_pop[k]})
          2'b10:   r_count[k] <= r_count[k] + CW'(1);
          2'b01:   r_count[k] <= r_count[k] - CW'(1);
          default: r_count[k] <= r_count[k];
        endcase
      end
    end
  end

  // NOTE: storage has no reset; the cleared counts already mark every entry
  // invalid, so resetting the array would only cost flops and reset routing.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (w_push[k]) r_mem[k][r_wptr[k]] <= InData;
    end
  end

`ifdef DEMUX_STATS_EN
  logic [7:0] r_acc_cnt [4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) r_acc_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (w_push[k] && (r_acc_cnt[k] != 8'hFF)) r_acc_cnt[k] <= r_acc_cnt[k] + 8'd1;
      end
    end
  end

  assign AcceptCnt = {r_acc_cnt[3], r_acc_cnt[2], r_acc_cnt[1], r_acc_cnt[0]};
`endif

endmodule

// File: tb/tb_demux_quad1_4.sv
// Directed self-checking bench for demux_quad1_4 (DEPTH=2); AcceptCnt checks
// are compiled in only when DEMUX_STATS_EN is defined.
module tb_demux_quad1_4;

  logic       clk;
  logic       rst_n;
  logic [3:0] InData;
  logic [1:0] InSel;
  logic       InValid;
  logic       InReady;
  logic [3:0] OutA, OutB, OutC, OutD;
  logic [3:0] OutValid;
  logic [3:0] OutReady;
`ifdef DEMUX_STATS_EN
  logic [31:0] AcceptCnt;
`endif

  int n_total = 0;
  int n_bad   = 0;

  demux_quad1_4 #(.DEPTH(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .InData   (InData),
    .InSel    (InSel),
    .InValid  (InValid),
    .InReady  (InReady),
    .OutA     (OutA),
    .OutB     (OutB),
    .OutC     (OutC),
    .OutD     (OutD),
    .OutValid (OutValid),
    .OutReady (OutReady)
`ifdef DEMUX_STATS_EN
    ,
    .AcceptCnt(AcceptCnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_idle(input logic [1:0] sel, input logic [3:0] data);
    InSel   = sel;
    InData  = data;
    InValid = 1'b1;
    tick();
    InValid = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    InData   = '0;
    InSel    = '0;
    InValid  = 1'b0;
    OutReady = '0;
    #1;
    check("rst_outvalid", 32'(OutValid), 32'h0);
    check("rst_inready",  32'(InReady),  32'h1);
    tick();
    rst_n = 1'b1;
    tick();

    // Single word to channel C with every consumer ready.
    OutReady = 4'hF;
    push_idle(2'd2, 4'h5);
    #1;
    check("c_valid", 32'(OutValid), 32'h4);
    check("c_data",  32'(OutC),     32'h5);
    tick();
    check("c_drained", 32'(OutValid), 32'h0);

    // Fill A, observe InReady per selected channel, push to B meanwhile.
    OutReady = 4'h0;
    push_idle(2'd0, 4'h3);
    push_idle(2'd0, 4'h9);
    InSel = 2'd0; #1;
    check("a_full_ready", 32'(InReady), 32'h0);
    InSel = 2'd1; #1;
    check("b_ready", 32'(InReady), 32'h1);
    push_idle(2'd1, 4'h7);
    #1;
    check("ab_valid", 32'(OutValid), 32'h3);
    check("b_data",   32'(OutB),     32'h7);
    OutReady = 4'b0001; #1;
    check("a_head0", 32'(OutA), 32'h3);
    tick();
    check("a_head1", 32'(OutA), 32'h9);
    tick();
    check("a_empty", 32'(OutValid), 32'h2);
    OutReady = 4'b0010;
    tick();
    OutReady = 4'h0;
    check("all_empty", 32'(OutValid), 32'h0);

    // Full channel: push refused even while its head pops; retry succeeds.
    push_idle(2'd0, 4'h1);
    push_idle(2'd0, 4'h2);
    InSel = 2'd0; InData = 4'h6; InValid = 1'b1; OutReady = 4'b0001; #1;
    check("full_nobypass", 32'(InReady), 32'h0);
    tick();
    check("retry_ready", 32'(InReady), 32'h1);
    check("after_pop_head", 32'(OutA), 32'h2);
    OutReady = 4'h0;
    tick();
    InValid = 1'b0;
    check("retry_head", 32'(OutA), 32'h2);
    check("retry_full", 32'(InReady), 32'h0);
    OutReady = 4'b0001;
    tick();
    check("retry_word", 32'(OutA), 32'h6);
    tick();
    check("retry_drained", 32'(OutValid), 32'h0);

    // Simultaneous push/pop in PARTIAL: count holds at 1, order preserved, pointers wrap.
    OutReady = 4'h0;
    push_idle(2'd0, 4'h0);
    OutReady = 4'b0001;
    for (int i = 1; i < 10; i++) begin
      InSel = 2'd0; InData = 4'(i); InValid = 1'b1; #1;
      check($sformatf("pp_head%0d", i - 1), 32'(OutA), 32'(i - 1));
      check("pp_ready", 32'(InReady), 32'h1);
      tick();
      check("pp_count1", 32'(OutValid), 32'h1);
    end
    InValid = 1'b0; #1;
    check("pp_last", 32'(OutA), 32'h9);
    tick();
    check("pp_drained", 32'(OutValid), 32'h0);

    // Asynchronous reset between edges discards buffered words on B and D.
    OutReady = 4'h0;
    push_idle(2'd1, 4'h8);
    push_idle(2'd3, 4'h4);
    check("bd_valid", 32'(OutValid), 32'hA);
    rst_n = 1'b0; #1;
    check("async_rst_valid", 32'(OutValid), 32'h0);
    check("async_rst_ready", 32'(InReady),  32'h1);
    #1;
    rst_n = 1'b1;
    tick();
    push_idle(2'd3, 4'hE);
    check("post_rst_valid", 32'(OutValid), 32'h8);
    check("post_rst_data",  32'(OutD),     32'hE);

`ifdef DEMUX_STATS_EN
    OutReady = 4'hF;
    tick();
    rst_n = 1'b0; #1;
    check("stats_rst", AcceptCnt, 32'h0);
    rst_n = 1'b1;
    tick();
    InSel = 2'd3; InData = 4'h1; InValid = 1'b1;
    for (int i = 0; i < 300; i++) tick();
    InValid = 1'b0;
    tick();
    check("stats_sat", AcceptCnt, 32'hFF00_0000);
    rst_n = 1'b0; #1;
    check("stats_clear", AcceptCnt, 32'h0);
    rst_n = 1'b1;
    tick();
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
